imem_loader: RTL and testbench

- Writer side of the instruction-memory read port used by the fetch stage.
- Accepts a byte stream from a host link (UART receiver or bench) and packs it into little-endian 32-bit words.
- Writes the words into instruction memory at consecutive word addresses starting at 0.
- Holds the processor clock-enable low until the image is completely written, then releases it.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_pack.sv | 44 ++++
 rtl/imem_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   - Default instruction-memory geometry (shared with the instruction memory).
//   - Header length of the load stream in bytes.
//   - Loader state encoding. ST_CSUM exists only when IMEM_LOADER_CSUM_EN is defined.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DEPTH  = 4096;
  localparam int HDR_BYTES   = 4;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
`ifdef IMEM_LOADER_CSUM_EN
    ST_CSUM = 3'd2,
`endif
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/imem_loader_pack.sv
// Byte-to-word packer for the loader stream.
// Bytes arrive least-significant first; on the fourth accepted byte the
// complete little-endian word is presented combinationally together with a
// one-cycle word_last pulse.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   take       a byte is accepted this cycle
//   data       the byte being accepted
//   word       assembled word (valid when word_last is 1)
//   word_last  the byte being accepted completes a word
module imem_loader_pack
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_last
);

  localparam logic [1:0] LAST_IDX = 2'(HDR_BYTES - 1);

  logic [23:0] sr_r;
  logic [1:0]  idx_r;

  // Shift accepted bytes in from the top; the index wraps 3 -> 0 by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r  <= 24'h000000;
      idx_r <= 2'd0;
    end else if (take) begin
      sr_r  <= {data, sr_r[23:8]};
      idx_r <= idx_r + 2'd1;
    end else begin
      sr_r  <= sr_r;
      idx_r <= idx_r;
    end
  end

  assign word      = {data, sr_r};
  assign word_last = take & (idx_r == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream (4-byte little-endian word
// count N followed by 4*N image bytes), writes the words to consecutive
// addresses from 0 and releases the processor clock-enable when complete.
// Optional macro IMEM_LOADER_CSUM_EN: one extra byte after the image must
// equal the XOR of all image bytes, otherwise the load is aborted.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid, in_data    byte stream input
//   in_ready             loader accepts a byte (transfer on in_valid & in_ready)
//   mem_we/addr/wdata    instruction-memory write port (registered)
//   proc_ce              processor clock-enable, high only after a good load
//   done, error          sticky completion / abort flags
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              proc_ce,
  output logic              done,
  output logic              error
);

  // One extra bit so a count of exactly DEPTH fits.
  localparam int CNT_W = ADDR_W + 1;

  state_t             state_r, state_next;
  logic [CNT_W-1:0]   n_r;
  logic [CNT_W-1:0]   word_cnt_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [31:0]        mem_wdata_r;
  logic               proc_ce_r, done_r, error_r;
  logic               fire_s, take_s, word_last_s, last_word_s;
  logic [31:0]        word_s;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]         xor_r;
`endif

  assign in_ready = (state_r == ST_HDR) || (state_r == ST_DATA)
`ifdef IMEM_LOADER_CSUM_EN
                    || (state_r == ST_CSUM)
`endif
                    ;
  assign fire_s      = in_valid & in_ready;
  assign take_s      = fire_s & ((state_r == ST_HDR) || (state_r == ST_DATA));
  assign last_word_s = ((word_cnt_r + CNT_W'(1)) == n_r);

  imem_loader_pack u_pack (
    .clk       (clk),
    .rst       (rst),
    .take      (take_s),
    .data      (in_data),
    .word      (word_s),
    .word_last (word_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; DONE and ERR are terminal until reset.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_HDR: begin
        if (word_last_s) begin
          if (word_s == 32'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_DONE;
`endif
          end else if (word_s > 32'(DEPTH)) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
          end
        end else begin
          state_next = ST_HDR;
        end
      end
      ST_DATA: begin
        if (word_last_s && last_word_s) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_next = ST_CSUM;
`else
          state_next = ST_DONE;
`endif
        end else begin
          state_next = ST_DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM: begin
        if (fire_s) begin
          state_next = (in_data == xor_r) ? ST_DONE : ST_ERR;
        end else begin
          state_next = ST_CSUM;
        end
      end
`endif
      ST_DONE: state_next = ST_DONE;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  // Word count capture, word counter and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r         <= '0;
      word_cnt_r  <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h00000000;
    end else begin
      mem_we_r <= 1'b0;
      if ((state_r == ST_HDR) && word_last_s) begin
        // Only the low bits matter: larger counts go to ERR and are never used.
        n_r        <= word_s[CNT_W-1:0];
        word_cnt_r <= '0;
      end else if ((state_r == ST_DATA) && word_last_s) begin
        mem_we_r    <= 1'b1;
        mem_addr_r  <= word_cnt_r[ADDR_W-1:0];
        mem_wdata_r <= word_s;
        word_cnt_r  <= word_cnt_r + CNT_W'(1);
      end else begin
        word_cnt_r <= word_cnt_r;
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running XOR of the image bytes; header bytes are excluded.
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_r <= 8'h00;
    end else if ((state_r == ST_HDR) && word_last_s) begin
      xor_r <= 8'h00;
    end else if ((state_r == ST_DATA) && take_s) begin
      xor_r <= xor_r ^ in_data;
    end else begin
      xor_r <= xor_r;
    end
  end
`endif

  // Status flags follow the state one cycle late, so done/proc_ce rise only
  // after the final write strobe has completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      proc_ce_r <= 1'b0;
    end else begin
      done_r    <= (state_r == ST_DONE);
      error_r   <= (state_r == ST_ERR);
      proc_ce_r <= (state_r == ST_DONE);
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign done      = done_r;
  assign error     = error_r;
  assign proc_ce   = proc_ce_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a per-cycle vector table for the basic
// back-to-back load and post-completion backpressure, plus hand-written
// sequences for gapped streams, empty/oversize headers, mid-load reset and
// (with IMEM_LOADER_CSUM_EN) the checksum byte.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, proc_ce, done, error;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .proc_ce   (proc_ce),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        we;
    logic        chk_ad;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        dn;
    logic        er;
    logic        ce;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          b2b_bad = 0;
  int          both_bad = 0;
  int          ovl_bad = 0;
  logic        prev_we = 1'b0;

  // Write-port monitor: logs every strobe and flags protocol violations.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      if (done || proc_ce) ovl_bad++;
    end
    if (mem_we && prev_we) b2b_bad++;
    if (done && error) both_bad++;
    prev_we = mem_we;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic ca,
                     input logic [11:0] a, input logic [31:0] w,
                     input logic dn, input logic er, input logic ce);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.rdy = rdy; t.we = we; t.chk_ad = ca;
    t.addr = a; t.wdata = w; t.dn = dn; t.er = er; t.ce = ce;
    vecs.push_back(t);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic wait_fin(input int max);
    int i;
    i = 0;
    while (!(done || error) && (i < max)) begin
      tick();
      i++;
    end
    check("wait_bound", 32'(done || error), 32'd1);
  endtask

  task automatic clear_log;
    wr_addr.delete();
    wr_data.delete();
  endtask

  logic [7:0] hdr2[4] = '{8'h02, 8'h00, 8'h00, 8'h00};
  logic [7:0] img[8]  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hF0, 8'h00};
  logic [7:0] img2[8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    // Table: reset, header N=2, image back-to-back, then DONE backpressure.
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 12'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b1, hdr2[i], 1'b1, 1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3)
        add(1'b0, 1'b1, img[i], 1'b1, 1'b1, 1'b1, 12'd0, 32'h00000013, 1'b0, 1'b0, 1'b0);
      else if (i == 7)
`ifdef IMEM_LOADER_CSUM_EN
        add(1'b0, 1'b1, img[i], 1'b1, 1'b1, 1'b1, 12'd1, 32'h00F000B3, 1'b0, 1'b0, 1'b0);
`else
        add(1'b0, 1'b1, img[i], 1'b0, 1'b1, 1'b1, 12'd1, 32'h00F000B3, 1'b0, 1'b0, 1'b0);
`endif
      else
        add(1'b0, 1'b1, img[i], 1'b1, 1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
`ifdef IMEM_LOADER_CSUM_EN
    // XOR of the eight image bytes is 8'h50.
    add(1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0, 1'b0);
`endif
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      bit ok;
      rst      = vecs[i].rst;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].dat;
      tick();
      n_vec++;
      ok = (in_ready === vecs[i].rdy) && (mem_we === vecs[i].we) &&
           (done === vecs[i].dn) && (error === vecs[i].er) && (proc_ce === vecs[i].ce);
      if (vecs[i].chk_ad)
        ok = ok && (mem_addr === vecs[i].addr) && (mem_wdata === vecs[i].wdata);
      if (!ok) begin
        n_bad++;
        $display("FAIL row %0d: got rdy=%b we=%b addr=%h wdata=%h done=%b err=%b ce=%b, expected rdy=%b we=%b addr=%h wdata=%h done=%b err=%b ce=%b",
                 i, in_ready, mem_we, mem_addr, mem_wdata, done, error, proc_ce,
                 vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].dn, vecs[i].er, vecs[i].ce);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;

    // Gapped stream: same image with in_valid toggling every cycle.
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) send(hdr2[i], 1'b1);
    for (int i = 0; i < 8; i++) send(img[i], 1'b1);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h50, 1'b1);
`endif
    wait_fin(8);
    check("gap_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("gap_addr0", 32'(wr_addr[0]), 32'd0);
      check("gap_data0", wr_data[0], 32'h00000013);
      check("gap_addr1", 32'(wr_addr[1]), 32'd1);
      check("gap_data1", wr_data[1], 32'h00F000B3);
    end
    check("gap_done", 32'(done), 32'd1);
    check("gap_ce", 32'(proc_ce), 32'd1);

    // Empty image.
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h00, 1'b0);
`endif
    wait_fin(4);
    check("empty_done", 32'(done), 32'd1);
    check("empty_err", 32'(error), 32'd0);
    check("empty_ce", 32'(proc_ce), 32'd1);
    check("empty_ready", 32'(in_ready), 32'd0);
    check("empty_nwrites", 32'(wr_addr.size()), 32'd0);

    // Oversize header: N = 4097.
    do_reset();
    clear_log();
    send(8'h01, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    wait_fin(4);
    check("over_err", 32'(error), 32'd1);
    check("over_done", 32'(done), 32'd0);
    check("over_ce", 32'(proc_ce), 32'd0);
    check("over_nwrites", 32'(wr_addr.size()), 32'd0);

    // Reset after six image bytes, then a fresh one-word load.
    do_reset();
    for (int i = 0; i < 4; i++) send(hdr2[i], 1'b0);
    for (int i = 0; i < 6; i++) send(img[i], 1'b0);
    do_reset();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_flags", {29'd0, done, error, proc_ce}, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    clear_log();
    for (int i = 0; i < 8; i++) send(img2[i], 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    send(8'h22, 1'b0);
`endif
    wait_fin(4);
    check("reload_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("reload_addr", 32'(wr_addr[0]), 32'd0);
      check("reload_data", wr_data[0], 32'hDEADBEEF);
    end
    check("reload_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CSUM_EN
    // Wrong checksum byte aborts the load.
    do_reset();
    for (int i = 0; i < 4; i++) send(hdr2[i], 1'b0);
    for (int i = 0; i < 8; i++) send(img[i], 1'b0);
    send(8'h5C, 1'b0);
    wait_fin(4);
    check("csum_bad_err", 32'(error), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_ce", 32'(proc_ce), 32'd0);
`endif

    check("no_b2b_we", 32'(b2b_bad), 32'd0);
    check("done_err_excl", 32'(both_bad), 32'd0);
    check("we_while_done", 32'(ovl_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
